// File: rtl/fp_div32_seq.sv
// Multi-cycle IEEE-754 single-precision divider with start/busy/done handshake.
// Restoring division develops one quotient bit per cycle; results truncate toward zero.
module fp_div32_seq #(
  parameter int QBITS = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  typedef enum logic [1:0] {IDLE, UNPACK, DIV, PACK} state_t;

  localparam int          CW   = $clog2(QBITS);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_t state, state_next;

  logic [31:0]      a_q, b_q;
  logic             sign_q;
  logic [7:0]       ea_q, eb_q;
  logic [23:0]      mb_q;
  logic [25:0]      rem_q;
  logic [QBITS-1:0] quo_q;
  logic [CW-1:0]    cnt_q;
  logic             special_q, spec_ovf_q;
  logic [31:0]      spec_res_q;

  // Operand decode straight from the captured operand registers
  logic [7:0]  ea_u, eb_u;
  logic [23:0] ma_u, mb_u;
  logic        sign_u, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign sign_u = a_q[31] ^ b_q[31];
  assign ea_u   = a_q[30:23];
  assign eb_u   = b_q[30:23];
  assign ma_u   = {1'b1, a_q[22:0]};
  assign mb_u   = {1'b1, b_q[22:0]};
  // exp=0 covers both true zeros and subnormals, which are flushed to zero
  assign a_zero = (ea_u == 8'd0);
  assign b_zero = (eb_u == 8'd0);
  assign a_inf  = (ea_u == 8'hFF) && (a_q[22:0] == 23'd0);
  assign b_inf  = (eb_u == 8'hFF) && (b_q[22:0] == 23'd0);
  assign a_nan  = (ea_u == 8'hFF) && (a_q[22:0] != 23'd0);
  assign b_nan  = (eb_u == 8'hFF) && (b_q[22:0] != 23'd0);

  logic        special_u, spec_ovf_u;
  logic [31:0] spec_res_u;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    special_u  = 1'b1;
    spec_ovf_u = 1'b0;
    spec_res_u = {sign_u, 31'd0};
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res_u = QNAN;
      spec_ovf_u = 1'b1;
    end else if (a_inf) begin
      spec_res_u = {sign_u, 8'hFF, 23'd0};
    end else if (b_zero) begin
      spec_res_u = {sign_u, 8'hFF, 23'd0};
      spec_ovf_u = 1'b1;
    end else if (!(a_zero || b_inf)) begin
      special_u  = 1'b0;
    end
  end

  // One restoring step; the first step runs in UNPACK from the freshly decoded mantissas
  logic [25:0] rem_cur, div_cur, rem_diff, rem_next;
  logic        qbit;

  always_comb begin
    rem_cur  = (state == UNPACK) ? {2'b00, ma_u} : rem_q;
    div_cur  = (state == UNPACK) ? {2'b00, mb_u} : {2'b00, mb_q};
    qbit     = (rem_cur >= div_cur);
    rem_diff = rem_cur - div_cur;
    rem_next = qbit ? (rem_diff << 1) : (rem_cur << 1);
  end

  logic signed [9:0] exp_p;
  logic [22:0]       man_p;
  logic              inexact_p, carry_p, ovf_p;
  logic [31:0]       res_p;
  logic [3:0]        flags_p;

  always_comb begin
    exp_p     = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'sd126
              + $signed({9'd0, quo_q[QBITS-1]});
    man_p     = quo_q[QBITS-1] ? quo_q[QBITS-2:1] : quo_q[QBITS-3:0];
    inexact_p = (rem_q != 26'd0) || (quo_q[QBITS-1] && quo_q[0]);
    res_p     = {sign_q, exp_p[7:0], man_p};
    carry_p   = inexact_p;
    ovf_p     = 1'b0;
    if (special_q) begin
      res_p   = spec_res_q;
      carry_p = 1'b0;
      ovf_p   = spec_ovf_q;
    end else if (exp_p >= 10'sd255) begin
      res_p   = {sign_q, 8'hFF, 23'd0};
      ovf_p   = 1'b1;
    end else if (exp_p <= 10'sd0) begin
      res_p   = {sign_q, 31'd0};
      carry_p = 1'b1;
    end
    flags_p = {res_p[31], (res_p[30:0] == 31'd0), carry_p, ovf_p};
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = UNPACK;
      UNPACK:  state_next = special_u ? PACK : DIV;
      DIV:     if (cnt_q == CW'(QBITS - 1)) state_next = PACK;
      PACK:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q        <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      ea_q       <= '0;
      eb_q       <= '0;
      mb_q       <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      special_q  <= 1'b0;
      spec_ovf_q <= 1'b0;
      spec_res_q <= '0;
      result     <= '0;
      flags      <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          a_q <= a;
          b_q <= b;
        end
        UNPACK: begin
          sign_q     <= sign_u;
          ea_q       <= ea_u;
          eb_q       <= eb_u;
          mb_q       <= mb_u;
          special_q  <= special_u;
          spec_ovf_q <= spec_ovf_u;
          spec_res_q <= spec_res_u;
          rem_q      <= rem_next;
          quo_q      <= {{(QBITS-1){1'b0}}, qbit};
          cnt_q      <= CW'(1);
        end
        DIV: begin
          rem_q <= rem_next;
          quo_q <= {quo_q[QBITS-2:0], qbit};
          cnt_q <= cnt_q + CW'(1);
        end
        PACK: begin
          result <= res_p;
          flags  <= flags_p;
          done   <= 1'b1;
          cnt_q  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_fp_div32_seq.sv
// Self-checking bench for fp_div32_seq: directed operands, scoreboard queue of
// expected result/flags/done-cycle, popped and compared whenever done pulses.
module tb_fp_div32_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;
  logic [3:0]  flags;

  fp_div32_seq #(.QBITS(25)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flags  (flags)
  );

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [3:0]  flg;
    int          done_cyc;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc equals n after the n-th rising edge
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks = n_checks + 1;
    assert (obs === expv) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic push_exp(input string tag, input logic [31:0] res, input logic [3:0] flg,
                          input int done_cyc, input int lat);
    exp_t e;
    e.tag      = tag;
    e.res      = res;
    e.flg      = flg;
    e.done_cyc = done_cyc;
    e.lat      = lat;
    sb_q.push_back(e);
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb_q.size()), 32'd0);
  endtask

  // Called at a falling edge; the start is sampled at the next rising edge k
  task automatic issue(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                       input logic [31:0] res, input logic [3:0] flg, input int lat);
    a     = op_a;
    b     = op_b;
    start = 1'b1;
    push_exp(tag, res, flg, cyc + 1 + lat, lat);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    drain(60);
  endtask

  function automatic logic [31:0] cont_res(input int j);
    // 6.0 / 2^(1+j) = 1.5 * 2^(1-j)
    return {1'b0, 8'(128 - j), 23'h400000};
  endfunction

  // Monitor: compares every done pulse with the head of the scoreboard
  initial begin
    int   busy_cnt;
    exp_t e;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (done) begin
          if (sb_q.size() == 0) begin
            check("spurious_done", 32'(done), 32'd0);
          end else begin
            e = sb_q.pop_front();
            check({e.tag, "_result"}, result, e.res);
            check({e.tag, "_flags"}, 32'(flags), 32'(e.flg));
            check({e.tag, "_done_cycle"}, 32'(cyc), 32'(e.done_cyc));
            check({e.tag, "_busy_at_done"}, 32'(busy), 32'd0);
            check({e.tag, "_busy_cycles"}, 32'(busy_cnt), 32'(e.lat));
          end
          busy_cnt = 0;
        end
      end
    end
  end

  initial begin
    int k0;
    reset = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_flags", 32'(flags), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Normal path
    issue("six_div_two", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 26);
    issue("one_third",   32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0010, 26);
    issue("neg_third",   32'hBF800000, 32'h40400000, 32'hBEAAAAAA, 4'b1010, 26);
    issue("pi_div_one",  32'h40490FDB, 32'h3F800000, 32'h40490FDB, 4'b0000, 26);
    issue("max_exp",     32'h7F000000, 32'h3F800000, 32'h7F000000, 4'b0000, 26);
    issue("min_exp",     32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000, 26);
    issue("overflow",    32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0001, 26);
    issue("underflow",   32'h00800000, 32'h4B000000, 32'h00000000, 4'b0110, 26);
    issue("exp_zero",    32'h00800000, 32'h40000000, 32'h00000000, 4'b0110, 26);

    // Special-case path
    issue("div_by_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0001, 2);
    issue("zero_zero",   32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0001, 2);
    issue("nan_in",      32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b0001, 2);
    issue("inf_inf",     32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b0001, 2);
    issue("inf_fin",     32'hFF800000, 32'h40000000, 32'hFF800000, 4'b1000, 2);
    issue("fin_inf",     32'h40000000, 32'h7F800000, 32'h00000000, 4'b0100, 2);
    issue("subn_num",    32'h00000001, 32'hBF800000, 32'h80000000, 4'b1100, 2);
    issue("subn_den",    32'h3F800000, 32'h80000005, 32'hFF800000, 4'b1001, 2);

    // start held high: only operands present at IDLE edges are captured
    k0 = cyc + 1;
    for (int m = 0; m < 3; m++)
      push_exp("cont", cont_res((k0 + 27 * m) % 4), 4'b0000, k0 + 27 * m + 26, 26);
    a     = 32'h40C00000;
    start = 1'b1;
    for (int i = 0; i <= 54; i++) begin
      b = {1'b0, 8'(128 + ((cyc + 1) % 4)), 23'd0};
      @(negedge clk);
      if (i == 27) begin
        check("cont_result_held", result, cont_res(k0 % 4));
        check("cont_restart_busy", 32'(busy), 32'd1);
      end
    end
    start = 1'b0;
    drain(60);

    // Reset mid-operation aborts without a done pulse
    a     = 32'h40C00000;
    b     = 32'h40000000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    sb_q.delete();
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", result, 32'h0);
    check("abort_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    check("abort_flags", 32'(flags), 32'h0);
    check("abort_result_after", result, 32'h0);
    issue("after_abort", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 26);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_div32_seq.md
# fp_div32_seq

Multi-cycle IEEE-754 single-precision divider for the execute stage. It takes the same 32-bit `a`/`b` operands as the ALU and produces `a / b` together with a 4-bit NZCV flag vector in ALU flag order. Its result and flags go to the execute-stage result mux and the condition-flag logic. Because a divide does not fit in one cycle, the unit uses a start/busy/done handshake, and the control unit stalls the processor while `busy` is high.

## Interface
- `QBITS`, default 25: number of quotient bits developed, one per cycle. Fixed at 25: 24 mantissa bits plus 1 normalisation bit.
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low. Low forces the IDLE state immediately.
- `start` input, 1 bit: request a divide. Sampled only in IDLE.
- `a` input, 32 bits: dividend, IEEE-754 single.
- `b` input, 32 bits: divisor, IEEE-754 single.
- `busy` output, 1 bit: high while an operation is in flight.
- `done` output, 1 bit: one-cycle pulse when `result` and `flags` update.
- `result` output, 32 bits: quotient. Holds its value until the next `done`.
- `flags` output, 4 bits: {neg, zero, carry, overflow}. Holds its value until the next `done`.

## Operation
- States: IDLE, UNPACK, DIV, PACK.
- **IDLE**
  - `start`=1 captures `a` and `b` into registers and moves to UNPACK.
  - `start`=0 stays in IDLE.
  - `start` is ignored in every other state, and operands are not re-sampled.
- **UNPACK**
  - Split each operand into sign, 8-bit exponent and 24-bit mantissa with the hidden bit.
  - Subnormal inputs (exp=0, frac≠0) are flushed to signed zero.
  - Sign of the result = sa XOR sb.
- **Special cases**, resolved in UNPACK. These skip DIV and go directly to PACK with the fixed result:
  - Either input NaN, 0/0, or inf/inf → 0x7FC00000, overflow=1.
  - finite/0 with a non-zero numerator → signed infinity, overflow=1.
  - inf/finite → signed infinity.
  - 0/non-zero or finite/inf → signed zero.
- **DIV** (restoring division)
  - Initial state: remainder R = ma (26 bits), quotient Q = 0, cycle counter = 0.
  - Each cycle:
    - If R ≥ mb: R ← (R−mb)<<1 and shift 1 into Q.
    - Otherwise: R ← R<<1 and shift 0 into Q.
  - After 25 cycles (counter 0..24), Q = floor(ma·2^24/mb), which lies in [2^23, 2^25).
- **PACK**
  - Exponent arithmetic is 10-bit signed. The biased exponent is E = ea − eb + 126 + Q[24].
  - Mantissa = Q[23:1] if Q[24]=1, else Q[22:0].
  - Rounding is round-toward-zero (truncation).
  - E ≥ 255 → signed infinity, overflow=1.
  - E ≤ 0 → signed zero (flush on underflow), carry=1.
  - carry = 1 when the result is inexact: final R ≠ 0, a 1 bit dropped from Q[0] during normalisation, or flush on underflow. Otherwise carry = 0.
  - neg = result[31] (0 for NaN).
  - zero = (result[30:0] == 0).
  - overflow = 1 only in the cases listed above.
  - The unit registers `result` and `flags`, pulses `done`, and returns to IDLE.

## Timing
- Reset values: state = IDLE, `busy`=0, `done`=0, `result`=32'h0, `flags`=4'h0, counter = 0.
- `start` sampled high at edge k puts the unit in UNPACK and `busy`=1 after edge k.
- Normal path: DIV occupies edges k+1..k+25 and PACK completes at edge k+26. After edge k+26: `done`=1, `busy`=0, and `result`/`flags` are valid. Latency is 26 cycles.
- Special-case path: UNPACK → PACK. `done`=1 after edge k+2.
- `done` is high for exactly one cycle. `busy` and `done` are never high together.
- Back-to-back operation: `start` may be high in the same cycle that `done` is high (the unit is in IDLE). The new operation begins at that edge and the previous `result` is still held.
- Reset low mid-operation: the unit aborts immediately without asserting `done`, and `result` clears to 0.

## Test plan
- 0x40C00000 / 0x40000000 (6.0/2.0), `start` at edge k → after edge k+26: `result`=0x40400000, `flags`=0000, `done` pulse of 1 cycle, `busy` high for exactly 26 cycles.
- 0x3F800000 / 0x40400000 (1.0/3.0) → `result`=0x3EAAAAAA, `flags`=0010 (inexact). 0xBF800000 / 0x40400000 → 0xBEAAAAAA, `flags`=1010.
- 0x3F800000 / 0x00000000 → `result`=0x7F800000, `flags`=0001, `done` after edge k+2. 0x00000000 / 0x00000000 → 0x7FC00000, `flags`=0001.
- 0x7F000000 / 0x3E800000 (2^127/0.25) → 0x7F800000, `flags`=0001. 0x00800000 / 0x4B000000 (underflow) → 0x00000000, `flags`=0110.
- `start` held high continuously with changing operands → only operands present in IDLE cycles are captured, and `done` occurs every 27 cycles on the normal path.
- Reset low at edge k+10 of a divide → `busy`=0 and `result`=0 immediately, no `done` pulse. A subsequent 6.0/2.0 completes correctly.
